dcm_lock_sequencer: RTL and testbench
=====================================

// Module: dcm_lock_sequencer
// PURPOSE
//  Supervises the DCM clock source from the reference-clock side: drives the DCM reset pulse,
//  waits for and qualifies LOCKED, then releases the system reset of the generated-clock logic.
//  Detects lock loss, re-asserts system reset and restarts the DCM; bounded retries on lock timeout.
// PARAMETERS
//  RST_PULSE_CYCLES    4       Clk cycles DcmRst is held high per restart (DCM needs >=3)
//  LOCK_TIMEOUT_CYCLES 100000  max Clk cycles in WAIT_LOCK before the DCM is restarted
//  LOCK_STABLE_CYCLES  64      consecutive synced-lock-high cycles required before release
// PORTS
//  Clk         in   1  reference clock (same clock feeding the DCM CLKIN)
//  RstN        in   1  asynchronous active-low reset
//  DcmLocked   in   1  DCM LOCKED, asynchronous to Clk
//  DcmStatus   in   8  DCM STATUS; bit2 = CLKFX stopped, asynchronous to Clk
//  DcmRst      out  1  DCM reset request
//  SysRstN     out  1  active-low reset for logic on the generated clock
//  Locked      out  1  high while in RUN
//  LockLost    out  1  one-cycle pulse on loss of lock while in RUN
//  RetryCount  out  8  count of lock timeouts, saturating at 255
// BEHAVIOUR
//  - Reset (RstN=0, async): state RESET_DCM, counter 0, DcmRst=1, SysRstN=0, Locked=0,
//    LockLost=0, RetryCount=0, synchronizers 0.
//  - DcmLocked and DcmStatus[2] pass through 2-FF synchronizers: LkS, FxStopS (2-cycle delay).
//  - All outputs are registered; each output changes in the cycle the state it depends on is entered.
//  - RESET_DCM: DcmRst=1, SysRstN=0, Locked=0. Held exactly RST_PULSE_CYCLES cycles
//    (counted from RstN release or from entry), then -> WAIT_LOCK, counter cleared.
//  - WAIT_LOCK: DcmRst=0. LkS=1 -> STABILIZE. Counter reaches LOCK_TIMEOUT_CYCLES-1 with
//    LkS=0 -> RESET_DCM, RetryCount+1 (held at 255). LkS=1 on the timeout cycle wins: -> STABILIZE.
//  - STABILIZE: counts consecutive LkS=1 cycles; LkS=0 -> WAIT_LOCK, timeout counter restarted.
//    After LOCK_STABLE_CYCLES cycles -> RUN.
//  - RUN: SysRstN=1, Locked=1. LkS=0 -> RESET_DCM; SysRstN=0, Locked=0 and LockLost=1 for one cycle,
//    all in the same cycle RESET_DCM is entered. RetryCount is not incremented on lock loss.
//  - Latency: DcmLocked rise -> SysRstN rise = LOCK_STABLE_CYCLES+3 Clk cycles (glitch-free);
//    DcmLocked fall in RUN -> SysRstN fall = 3 cycles.
//  - SysRstN asserts asynchronously with RstN and deasserts synchronously to Clk only.
//  - Counters are sized by $clog2 of the largest parameter; no wrap occurs inside any state.
//  - RetryCount is cleared only by RstN.
// CONFIGURATION
//  DCM_SEQ_FX_STOP_CHECK_EN defined: FxStopS=1 in WAIT_LOCK, STABILIZE or RUN -> RESET_DCM.
//    In RUN this also drops SysRstN/Locked and pulses LockLost. If FxStopS=1 and the WAIT_LOCK
//    timeout occur in the same cycle, RetryCount increments once. The check has priority over LkS.
//  Macro not defined: DcmStatus is ignored (port kept, unconnected internally) and only DcmLocked
//    is monitored.
// TESTING  (RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=8)
//  1. RstN low 3 cycles then high, DcmLocked=0 -> DcmRst high 4 cycles after release, then 0;
//     SysRstN=0, RetryCount=0.
//  2. DcmLocked rises 10 cycles after DcmRst falls and stays high -> SysRstN and Locked rise
//     exactly 11 cycles after the DcmLocked edge.
//  3. DcmLocked held 0 -> DcmRst re-pulses every 54 cycles (4 held + 50 waiting); RetryCount
//     1,2,3...; forced to 300 timeouts it reads 255.
//  4. In RUN, DcmLocked drops for 1 cycle -> 3 cycles later SysRstN=0, Locked=0, LockLost pulses
//     once, DcmRst high 4 cycles.
//  5. DcmLocked toggles 1 for 5 cycles, 0, then 1 -> no release at the 5-cycle run; release
//     11 cycles after the final rise.
//  6. With DCM_SEQ_FX_STOP_CHECK_EN, DcmStatus[2]=1 in RUN -> restart as in 4.
//     Without the macro, Locked stays 1. In both builds, RstN low mid-STABILIZE forces the
//     reset values immediately.

Source files
------------

// File: rtl/dcm_lock_sequencer.sv
// dcm_lock_sequencer: drives the DCM reset pulse, qualifies LOCKED and releases the generated-clock system reset.
// Defining DCM_SEQ_FX_STOP_CHECK_EN also restarts the DCM when DcmStatus[2] (CLKFX stopped) is seen.
module dcm_lock_sequencer #(
   parameter int RST_PULSE_CYCLES    = 4,
   parameter int LOCK_TIMEOUT_CYCLES = 100000,
   parameter int LOCK_STABLE_CYCLES  = 64
) (
   input  logic       Clk,
   input  logic       RstN,
   input  logic       DcmLocked,
   input  logic [7:0] DcmStatus,
   output logic       DcmRst,
   output logic       SysRstN,
   output logic       Locked,
   output logic       LockLost,
   output logic [7:0] RetryCount
);
   localparam int MaxAB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MaxCycles = (MaxAB > LOCK_STABLE_CYCLES) ? MaxAB : LOCK_STABLE_CYCLES;
   localparam int CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [CntW-1:0] PulseLast = CntW'(RST_PULSE_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);

   typedef enum logic [1:0] {RESET_DCM, WAIT_LOCK, STABILIZE, RUN} stateT;

   stateT state;
   logic [CntW-1:0] cnt;
   logic lkMeta, lkS, fxStop, waitDone, unusedStatus;
   logic [7:0] retryNext;

`ifdef DCM_SEQ_FX_STOP_CHECK_EN
   logic fxMeta, fxStopS;
   always_ff @(posedge Clk or negedge RstN)
      if (!RstN) {fxMeta, fxStopS} <= 2'b00;
      else {fxMeta, fxStopS} <= {DcmStatus[2], fxMeta};
   assign fxStop = fxStopS;
`else
   assign fxStop = 1'b0;
`endif

   assign unusedStatus = ^DcmStatus;
   assign waitDone = cnt == TimeoutLast;
   assign retryNext = RetryCount + 8'(RetryCount != 8'hFF);

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state <= RESET_DCM;
         cnt <= '0;
         DcmRst <= 1'b1;
         SysRstN <= 1'b0;
         Locked <= 1'b0;
         LockLost <= 1'b0;
         RetryCount <= 8'd0;
         lkMeta <= 1'b0;
         lkS <= 1'b0;
      end else begin
         lkMeta <= DcmLocked;
         lkS <= lkMeta;
         LockLost <= 1'b0;
         case (state)
            RESET_DCM:
               if (cnt == PulseLast) begin
                  state <= WAIT_LOCK;
                  cnt <= '0;
                  DcmRst <= 1'b0;
               end else cnt <= cnt + CntW'(1);
            WAIT_LOCK:
               if (fxStop || (!lkS && waitDone)) begin
                  state <= RESET_DCM;
                  cnt <= '0;
                  DcmRst <= 1'b1;
                  if (waitDone) RetryCount <= retryNext;
               end else if (lkS) begin
                  state <= STABILIZE;
                  cnt <= '0;
               end else cnt <= cnt + CntW'(1);
            STABILIZE:
               if (fxStop) begin
                  state <= RESET_DCM;
                  cnt <= '0;
                  DcmRst <= 1'b1;
               end else if (!lkS) begin
                  state <= WAIT_LOCK;
                  cnt <= '0;
               end else if (cnt == StableLast) begin
                  state <= RUN;
                  cnt <= '0;
                  SysRstN <= 1'b1;
                  Locked <= 1'b1;
               end else cnt <= cnt + CntW'(1);
            RUN:
               // Lock loss: drop the system reset and flag it in the same cycle the restart begins
               if (fxStop || !lkS) begin
                  state <= RESET_DCM;
                  cnt <= '0;
                  DcmRst <= 1'b1;
                  SysRstN <= 1'b0;
                  Locked <= 1'b0;
                  LockLost <= 1'b1;
               end
         endcase
      end
   end
endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// tb_dcm_lock_sequencer: directed checks of reset pulse, lock qualification, timeouts and lock loss.
module tb_dcm_lock_sequencer;
   logic Clk = 1'b0;
   logic RstN = 1'b0;
   logic DcmLocked = 1'b0;
   logic [7:0] DcmStatus = 8'd0;
   logic DcmRst, SysRstN, Locked, LockLost;
   logic [7:0] RetryCount;
   int total = 0;
   int bad = 0;

   dcm_lock_sequencer #(
      .RST_PULSE_CYCLES(4),
      .LOCK_TIMEOUT_CYCLES(50),
      .LOCK_STABLE_CYCLES(8)
   ) dut (
      .Clk(Clk),
      .RstN(RstN),
      .DcmLocked(DcmLocked),
      .DcmStatus(DcmStatus),
      .DcmRst(DcmRst),
      .SysRstN(SysRstN),
      .Locked(Locked),
      .LockLost(LockLost),
      .RetryCount(RetryCount)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   initial begin
      // reset held 3 cycles
      tick(3);
      check("rst_dcmrst", DcmRst, 1);
      check("rst_sysrstn", SysRstN, 0);
      check("rst_locked", Locked, 0);
      check("rst_locklost", LockLost, 0);
      check("rst_retry", RetryCount, 0);
      RstN = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick(1);
         check("pulse_dcmrst", DcmRst, i < 4);
         check("pulse_sysrstn", SysRstN, 0);
      end
      check("pulse_retry", RetryCount, 0);

      // first lock: release 11 cycles after the DcmLocked edge
      tick(10);
      DcmLocked = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick(1);
         check("lock_sysrstn", SysRstN, i == 11);
         check("lock_locked", Locked, i == 11);
         check("lock_dcmrst", DcmRst, 0);
      end
      check("lock_retry", RetryCount, 0);

      // one-cycle lock dropout in RUN, then relock
      DcmLocked = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick(1);
         if (i == 1) DcmLocked = 1'b1;
         check("drop_sysrstn", SysRstN, (i < 3) || (i == 16));
         check("drop_locked", Locked, (i < 3) || (i == 16));
         check("drop_locklost", LockLost, i == 3);
         check("drop_dcmrst", DcmRst, (i >= 3) && (i < 7));
         check("drop_retry", RetryCount, 0);
      end

      // lock loss, then a 5-cycle lock burst that must not release
      DcmLocked = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick(1);
         check("loss_locklost", LockLost, i == 3);
         check("loss_dcmrst", DcmRst, (i >= 3) && (i < 7));
      end
      DcmLocked = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         tick(1);
         if (i == 5) DcmLocked = 1'b0;
         if (i == 6) DcmLocked = 1'b1;
         check("burst_sysrstn", SysRstN, i == 17);
         check("burst_locked", Locked, i == 17);
      end

      // lock lost for good: periodic restarts, RetryCount saturates
      DcmLocked = 1'b0;
      for (int i = 1; i <= 57 + 54 * 299 + 5; i++) begin
         int expRetry;
         tick(1);
         expRetry = (i < 57) ? 0 : ((i - 57) / 54 + 1);
         if (expRetry > 255) expRetry = 255;
         check("to_dcmrst", DcmRst, ((i >= 3) && (i < 7)) || ((i >= 57) && (((i - 57) % 54) < 4)));
         check("to_retry", RetryCount, expRetry);
         check("to_sysrstn", SysRstN, i < 3);
         check("to_locklost", LockLost, i == 3);
      end

      // relock, then CLKFX-stopped status in RUN
      DcmLocked = 1'b1;
      tick(20);
      check("fx_pre_locked", Locked, 1);
      DcmStatus = 8'h04;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
`ifdef DCM_SEQ_FX_STOP_CHECK_EN
         check("fx_locked", Locked, i < 3);
         check("fx_locklost", LockLost, i == 3);
         check("fx_dcmrst", DcmRst, i >= 3);
`else
         check("fx_locked", Locked, 1);
         check("fx_locklost", LockLost, 0);
         check("fx_dcmrst", DcmRst, 0);
`endif
      end
      check("fx_retry", RetryCount, 255);
      DcmStatus = 8'h00;
      tick(20);
      check("fx_post_locked", Locked, 1);

      // async reset in the middle of STABILIZE
      DcmLocked = 1'b0;
      tick(7);
      DcmLocked = 1'b1;
      tick(5);
      check("mid_retry_before", RetryCount, 255);
      RstN = 1'b0;
      #1;
      check("mid_dcmrst", DcmRst, 1);
      check("mid_sysrstn", SysRstN, 0);
      check("mid_locked", Locked, 0);
      check("mid_locklost", LockLost, 0);
      check("mid_retry", RetryCount, 0);
      tick(2);
      RstN = 1'b1;
      tick(2);
      check("mid_after_dcmrst", DcmRst, 1);
      check("mid_after_sysrstn", SysRstN, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
